vga_fb_reader: RTL and testbench

- Framebuffer fetch stage, directly upstream of the vga timing generator.
- Reads pixels from the framebuffer in SoC memory over a Wishbone classic master port, one 32-bit word per pixel (RGB in bits 23:0).
- Buffers pixels in an internal show-ahead FIFO.
- Delivers one pixel per cycle to the timing stage, which asserts pix_req during active display.

---
 rtl/vga_fb_reader.sv | 133 +++++++++++++
 tb/tb_vga_fb_reader.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_reader.sv
// Framebuffer fetch stage: reads one frame of pixels over a Wishbone classic master port
// into a show-ahead FIFO and delivers one registered pixel per requested cycle.
module vga_fb_reader #(
    parameter int unsigned HDISP      = 800,
    parameter int unsigned VDISP      = 480,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 256
) (
    input  logic                        pixel_clk,
    input  logic                        pixel_rst,
    input  logic                        frame_start,
    input  logic                        pix_req,
    output logic [23:0]                 pix_rgb,
    output logic                        pix_valid,
    output logic                        underflow,
    output logic [$clog2(FIFO_DEPTH):0] fill_level,
    output logic [31:0]                 wb_adr_o,
    input  logic [31:0]                 wb_dat_i,
    output logic                        wb_cyc_o,
    output logic                        wb_stb_o,
    output logic                        wb_we_o,
    output logic [3:0]                  wb_sel_o,
    input  logic                        wb_ack_i
);

    localparam int unsigned TOTAL = HDISP * VDISP;
    localparam int unsigned CW    = $clog2(TOTAL + 1);
    localparam int unsigned PW    = $clog2(FIFO_DEPTH);
    localparam int unsigned FW    = PW + 1;

    localparam logic [CW-1:0] TOTAL_W = CW'(TOTAL);
    localparam logic [FW-1:0] DEPTH_W = FW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StWaitFrame, StIdle, StBus, StDone} state_e;

    state_e        state;
    logic [CW-1:0] word_cnt;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [23:0]   mem [FIFO_DEPTH];
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          unused_dat_hi;

    assign wb_we_o       = 1'b0;
    assign wb_sel_o      = 4'hF;
    assign unused_dat_hi = ^wb_dat_i[31:24];

    assign fifo_empty = (fill_level == '0);
    // Only a request in flight may push; a late ack in any other state is dropped.
    assign push       = pixel_rst && !frame_start && (state == StBus) && wb_ack_i;
    assign pop        = pix_req && !fifo_empty;

    always_ff @(posedge pixel_clk) begin
        if (push) begin
            mem[wr_ptr] <= wb_dat_i[23:0];
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (!pixel_rst) begin
            state      <= StWaitFrame;
            word_cnt   <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fill_level <= '0;
            pix_rgb    <= '0;
            pix_valid  <= 1'b0;
            underflow  <= 1'b0;
            wb_adr_o   <= BASE_ADDR;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
        end else if (frame_start) begin
            state      <= StIdle;
            word_cnt   <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fill_level <= '0;
            pix_valid  <= 1'b0;
            underflow  <= 1'b0;
            wb_adr_o   <= BASE_ADDR;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
        end else begin
            unique case (state)
                StWaitFrame: state <= StWaitFrame;
                StIdle: begin
                    if (word_cnt == TOTAL_W) begin
                        state <= StDone;
                    end else if (fill_level < DEPTH_W) begin
                        state    <= StBus;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                    end
                end
                StBus: begin
                    if (wb_ack_i) begin
                        state    <= StIdle;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_adr_o <= wb_adr_o + 32'd4;
                        word_cnt <= word_cnt + CW'(1);
                    end
                end
                StDone: state <= StDone;
                default: state <= StWaitFrame;
            endcase

            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            fill_level <= fill_level + FW'(push) - FW'(pop);

            // An empty FIFO yields black so the timing stage never stalls.
            if (pix_req) begin
                pix_valid <= 1'b1;
                if (fifo_empty) begin
                    pix_rgb   <= '0;
                    underflow <= 1'b1;
                end else begin
                    pix_rgb <= mem[rd_ptr];
                end
            end else begin
                pix_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_reader.sv
// Bench for vga_fb_reader: queue-based reference model checked every cycle, a Wishbone
// slave with programmable ack latency, and directed scenarios with literal expectations.
module tb_vga_fb_reader;

    localparam int unsigned HDISP = 4;
    localparam int unsigned VDISP = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TOTAL = HDISP * VDISP;
    localparam logic [31:0] BASE  = 32'h100;

    logic        clk         = 1'b0;
    logic        rst_n       = 1'b0;
    logic        frame_start = 1'b0;
    logic        pix_req     = 1'b0;
    logic [23:0] pix_rgb;
    logic        pix_valid;
    logic        underflow;
    logic [2:0]  fill_level;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_i    = 32'h0;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i;
    logic        slave_ack   = 1'b0;
    logic        stray_ack   = 1'b0;

    int unsigned n_chk     = 0;
    int unsigned n_fail    = 0;
    int unsigned slave_lat = 1;
    int unsigned wait_cnt  = 0;
    bit          slave_en  = 1'b1;

    assign wb_ack_i = slave_ack | stray_ack;

    always #5 clk = ~clk;

    vga_fb_reader #(
        .HDISP      (HDISP),
        .VDISP      (VDISP),
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .pixel_clk   (clk),
        .pixel_rst   (rst_n),
        .frame_start (frame_start),
        .pix_req     (pix_req),
        .pix_rgb     (pix_rgb),
        .pix_valid   (pix_valid),
        .underflow   (underflow),
        .fill_level  (fill_level),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_i    (wb_dat_i),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_we_o     (wb_we_o),
        .wb_sel_o    (wb_sel_o),
        .wb_ack_i    (wb_ack_i)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Slave returns the address with junk in bits 31:24, which must be ignored.
    always @(posedge clk) begin
        #1;
        if (!slave_en) begin
            wait_cnt  = 0;
            slave_ack = 1'b0;
        end else if (slave_ack) begin
            slave_ack = 1'b0;
        end else if (wb_cyc_o && wb_stb_o) begin
            if (wait_cnt >= slave_lat) begin
                slave_ack = 1'b1;
                wb_dat_i  = wb_adr_o ^ 32'hAB00_0000;
                wait_cnt  = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Reference model: a pixel queue plus the frame's next address and word count.
    logic [23:0] q[$];
    logic [31:0] rd_log[$];
    logic [23:0] m_rgb     = 24'h0;
    logic        m_valid   = 1'b0;
    logic        m_under   = 1'b0;
    logic        m_started = 1'b0;
    logic [31:0] m_addr    = BASE;
    int unsigned m_words   = 0;

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("fill_level", 32'(fill_level), q.size());
            chk("pix_valid", 32'(pix_valid), 32'(m_valid));
            chk("pix_rgb", 32'(pix_rgb), 32'(m_rgb));
            chk("underflow", 32'(underflow), 32'(m_under));
            chk("wb_adr", wb_adr_o, m_addr);
            chk("wb_we", 32'(wb_we_o), 32'h0);
            chk("wb_sel", 32'(wb_sel_o), 32'hF);
            chk("wb_stb_follows_cyc", 32'(wb_stb_o), 32'(wb_cyc_o));
            if (wb_cyc_o) begin
                chk("fetch_allowed",
                    32'(m_started && (m_words < TOTAL) && (q.size() < DEPTH)), 32'h1);
            end
            if (!rst_n) begin
                q.delete();
                m_rgb     = 24'h0;
                m_valid   = 1'b0;
                m_under   = 1'b0;
                m_started = 1'b0;
                m_addr    = BASE;
                m_words   = 0;
            end else if (frame_start) begin
                q.delete();
                m_valid   = 1'b0;
                m_under   = 1'b0;
                m_started = 1'b1;
                m_addr    = BASE;
                m_words   = 0;
            end else begin
                if (pix_req) begin
                    m_valid = 1'b1;
                    if (q.size() == 0) begin
                        m_rgb   = 24'h0;
                        m_under = 1'b1;
                    end else begin
                        m_rgb = q.pop_front();
                    end
                end else begin
                    m_valid = 1'b0;
                end
                if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
                    q.push_back(wb_dat_i[23:0]);
                    rd_log.push_back(wb_adr_o);
                    m_addr = m_addr + 32'd4;
                    m_words++;
                end
            end
        end
    end

    function automatic logic [31:0] log_at(input int i);
        return (i < rd_log.size()) ? rd_log[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic wait_ack_fill2();
        int n = 0;
        while (!(wb_ack_i && fill_level == 3'd2) && n < 40) begin
            step();
            n++;
        end
        chk("wait_ack_at_fill2", 32'(wb_ack_i && fill_level == 3'd2), 32'h1);
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    initial begin
        int n;
        step();
        step();
        rst_n = 1'b1;
        chk("rst_fill", 32'(fill_level), 32'h0);
        chk("rst_cyc", 32'(wb_cyc_o), 32'h0);
        chk("rst_adr", wb_adr_o, 32'h100);
        chk("rst_valid", 32'(pix_valid), 32'h0);
        chk("rst_rgb", 32'(pix_rgb), 32'h0);
        chk("rst_underflow", 32'(underflow), 32'h0);
        repeat (3) step();
        chk("wait_frame_no_fetch", 32'(wb_cyc_o), 32'h0);

        // Fill with no consumer: four reads then idle with a full FIFO.
        pulse_frame_start();
        chk("fs_cyc_plus1", 32'(wb_cyc_o), 32'h0);
        step();
        chk("fs_cyc_plus2", 32'(wb_cyc_o), 32'h1);
        chk("fs_first_adr", wb_adr_o, 32'h100);
        repeat (25) step();
        chk("fill_reads", rd_log.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("fill_read_adr", log_at(i), BASE + 32'(4 * i));
        end
        chk("fill_full", 32'(fill_level), 32'h4);
        chk("fill_cyc_idle", 32'(wb_cyc_o), 32'h0);

        // Eight requests, each issued when a pixel is available.
        for (int k = 0; k < 8; k++) begin
            n = 0;
            while (fill_level == 3'd0 && n < 40) begin
                step();
                n++;
            end
            chk("wait_fill_nonzero", 32'(fill_level != 3'd0), 32'h1);
            pix_req = 1'b1;
            step();
            pix_req = 1'b0;
            chk("seq_valid", 32'(pix_valid), 32'h1);
            chk("seq_rgb", 32'(pix_rgb), BASE + 32'(4 * k));
        end
        repeat (30) step();
        chk("frame_reads", rd_log.size(), 32'd8);
        chk("frame_last_adr", log_at(7), 32'h11C);
        chk("done_cyc", 32'(wb_cyc_o), 32'h0);
        chk("done_underflow", 32'(underflow), 32'h0);

        // Continuous demand against a slow slave.
        slave_lat = 3;
        pulse_frame_start();
        chk("fs_valid_clr", 32'(pix_valid), 32'h0);
        chk("fs_fill_clr", 32'(fill_level), 32'h0);
        pix_req = 1'b1;
        step();
        chk("uf_rise", 32'(underflow), 32'h1);
        chk("uf_valid", 32'(pix_valid), 32'h1);
        chk("uf_black", 32'(pix_rgb), 32'h0);
        repeat (30) step();
        chk("uf_sticky", 32'(underflow), 32'h1);
        pix_req = 1'b0;
        pulse_frame_start();
        chk("uf_cleared", 32'(underflow), 32'h0);
        chk("uf_fill_clr", 32'(fill_level), 32'h0);

        // frame_start coinciding with an ack discards that word.
        slave_lat = 1;
        wait_ack_fill2();
        pulse_frame_start();
        chk("fs_ack_fill", 32'(fill_level), 32'h0);
        chk("fs_ack_cyc", 32'(wb_cyc_o), 32'h0);
        chk("fs_ack_adr", wb_adr_o, 32'h100);
        chk("fs_ack_underflow", 32'(underflow), 32'h0);
        step();
        chk("fs_ack_refetch_cyc", 32'(wb_cyc_o), 32'h1);
        chk("fs_ack_refetch_adr", wb_adr_o, 32'h100);

        // Push and pop in the same cycle.
        wait_ack_fill2();
        pix_req = 1'b1;
        step();
        pix_req = 1'b0;
        chk("pushpop_fill", 32'(fill_level), 32'h2);
        chk("pushpop_valid", 32'(pix_valid), 32'h1);
        chk("pushpop_rgb", 32'(pix_rgb), 32'h100);

        // Reset in the middle of a bus cycle, then a late ack.
        slave_lat = 3;
        n = 0;
        while (!(wb_cyc_o && !wb_ack_i) && n < 40) begin
            step();
            n++;
        end
        chk("wait_bus", 32'(wb_cyc_o && !wb_ack_i), 32'h1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_cyc", 32'(wb_cyc_o), 32'h0);
        chk("mid_rst_stb", 32'(wb_stb_o), 32'h0);
        chk("mid_rst_fill", 32'(fill_level), 32'h0);
        chk("mid_rst_adr", wb_adr_o, 32'h100);
        chk("mid_rst_valid", 32'(pix_valid), 32'h0);
        chk("mid_rst_rgb", 32'(pix_rgb), 32'h0);
        chk("mid_rst_underflow", 32'(underflow), 32'h0);
        slave_en  = 1'b0;
        stray_ack = 1'b1;
        step();
        stray_ack = 1'b0;
        chk("late_ack_fill", 32'(fill_level), 32'h0);
        chk("late_ack_adr", wb_adr_o, 32'h100);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("post_rst_no_fetch", 32'(wb_cyc_o), 32'h0);
        end
        slave_en = 1'b1;
        pulse_frame_start();
        chk("restart_cyc_plus1", 32'(wb_cyc_o), 32'h0);
        step();
        chk("restart_cyc_plus2", 32'(wb_cyc_o), 32'h1);
        chk("restart_adr", wb_adr_o, 32'h100);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
